// File: rtl/gauss_frame_sequencer_if.sv
// gauss_frame_sequencer_if: upstream pixel, filter pipeline and downstream FIFO signals of the sequencer
interface gauss_frame_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] din;
  logic              rd_en_down;
  logic [DATA_W-1:0] filt_din;
  logic              filt_en;
  logic              filt_rst;
  logic [DATA_W-1:0] filt_dout;
  logic              rd_en_up;
  logic [DATA_W-1:0] dout;
  logic              valid_out;
  logic              empty;
  logic              frame_done;
  modport master (
    output valid, din, filt_dout, rd_en_up,
    input  rd_en_down, filt_din, filt_en, filt_rst, dout, valid_out, empty, frame_done
  );
  modport slave (
    input  valid, din, filt_dout, rd_en_up,
    output rd_en_down, filt_din, filt_en, filt_rst, dout, valid_out, empty, frame_done
  );
endinterface

// File: rtl/gauss_frame_sequencer.sv
// gauss_frame_sequencer: feeds a clock-enabled filter with padded rows and a frame flush, credit-gated into an output FIFO
module gauss_frame_sequencer #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 400,
  parameter int IMG_H      = 300,
  parameter int ROW_PAD    = 2,
  parameter int FLUSH_LEN  = 804,
  parameter int FILT_LAT   = 804,
  parameter int FIFO_DEPTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  gauss_frame_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NW = $clog2(((ROW_PAD > FLUSH_LEN) ? ROW_PAD : FLUSH_LEN) + 1);
  localparam int PW = $clog2(FILT_LAT + 2);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ROW   = 3'd1;
  localparam logic [2:0] S_PAD   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_CLR   = 3'd4;
  logic [2:0]        r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [NW-1:0]     r_cnt;
  logic [PW-1:0]     r_prime;
  logic              r_wr_pend;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid_out;
  logic [AW+1:0]     w_used;
  logic              w_adv;
  logic              w_in_row;
  logic              w_zero;
  logic              w_rd_en_down;
  logic              w_acc;
  logic              w_filt_en;
  logic              w_push;
  logic              w_pop;
  logic              w_col_last;
  logic              w_row_last;
  // An in-flight filter output still owns a FIFO slot even if it ends up discarded.
  assign w_used       = (AW+2)'(r_count) + (AW+2)'(r_wr_pend);
  assign w_adv        = w_used < (AW+2)'(FIFO_DEPTH);
  assign w_in_row     = (r_state == S_IDLE) || (r_state == S_ROW);
  assign w_zero       = (r_state == S_PAD) || (r_state == S_FLUSH);
  assign w_rd_en_down = w_in_row && w_adv;
  assign w_acc        = bus.valid && w_rd_en_down;
  assign w_filt_en    = w_in_row ? w_acc : (w_zero && w_adv);
  assign w_push       = r_wr_pend && (r_prime == PW'(FILT_LAT));
  assign w_pop        = bus.rd_en_up && (r_count != '0);
  assign w_col_last   = r_col == CW'(IMG_W - 1);
  assign w_row_last   = r_row == RW'(IMG_H - 1);
  assign bus.rd_en_down = w_rd_en_down;
  assign bus.filt_en    = w_filt_en;
  assign bus.filt_din   = w_acc ? bus.din : '0;
  assign bus.filt_rst   = r_state == S_CLR;
  assign bus.frame_done = r_state == S_CLR;
  assign bus.empty      = r_count == '0;
  assign bus.dout       = r_dout;
  assign bus.valid_out  = r_valid_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ROW: if (w_acc) begin
          r_col   <= w_col_last ? '0 : r_col + 1'b1;
          r_state <= w_col_last ? S_PAD : S_ROW;
        end
        S_PAD: if (w_adv) begin
          r_cnt   <= (r_cnt == NW'(ROW_PAD - 1)) ? '0 : r_cnt + 1'b1;
          r_state <= (r_cnt != NW'(ROW_PAD - 1)) ? S_PAD : w_row_last ? S_FLUSH : S_ROW;
          r_row   <= (r_cnt == NW'(ROW_PAD - 1) && !w_row_last) ? r_row + 1'b1 : r_row;
        end
        S_FLUSH: if (w_adv) begin
          r_cnt   <= (r_cnt == NW'(FLUSH_LEN - 1)) ? '0 : r_cnt + 1'b1;
          r_state <= (r_cnt == NW'(FLUSH_LEN - 1)) ? S_CLR : S_FLUSH;
        end
        default: begin
          r_state <= S_IDLE;
          r_col   <= '0;
          r_row   <= '0;
        end
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_pend   <= 1'b0;
      r_prime     <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_wr_pend   <= w_filt_en;
      r_prime     <= (r_state == S_CLR) ? '0 : (r_wr_pend && !w_push) ? r_prime + 1'b1 : r_prime;
      r_wp        <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp        <= w_pop ? r_rp + 1'b1 : r_rp;
      r_dout      <= w_pop ? r_mem[r_rp] : r_dout;
      r_valid_out <= w_pop;
      r_count     <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= bus.filt_dout;
endmodule

// File: doc/gauss_frame_sequencer.md
# gauss_frame_sequencer

Parametrised row/frame sequencer between the down-sampler and up-sampler stages of a scale-space octave. It accepts a raster pixel stream, drives an external clock-enabled Gaussian filter pipeline, and inserts zero padding after every row and a zero flush after every frame. It pulses the filter reset between frames and buffers filter output in an internal FIFO. Credit-based backpressure replaces free-running writes, so the FIFO cannot overflow for any image geometry.

## Interface
- DATA_W, 8, pixel width
- IMG_W, 400, pixels per row (≥2)
- IMG_H, 300, rows per frame (≥1)
- ROW_PAD, 2, zero samples inserted after each row (≥1)
- FLUSH_LEN, 804, zero samples inserted after last row's padding (≥FILT_LAT)
- FILT_LAT, 804, filter latency in enabled cycles; first FILT_LAT outputs per frame discarded
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥2)
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- valid  in  1  upstream pixel present
- din  in  DATA_W  upstream pixel
- rd_en_down  out  1  ready to upstream; pixel accepted when valid && rd_en_down
- filt_din  out  DATA_W  filter input
- filt_en  out  1  filter clock enable
- filt_rst  out  1  filter synchronous reset
- filt_dout  in  DATA_W  filter output, updated by each edge on which filt_en=1
- rd_en_up  in  1  downstream read request
- dout  out  DATA_W  FIFO read data
- valid_out  out  1  dout valid
- empty  out  1  FIFO empty
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, ROW, PAD, FLUSH, CLR. Counters: col (0..IMG_W-1), row (0..IMG_H-1), pad/flush cnt, prime cnt (0..FILT_LAT).
- credit = FIFO_DEPTH − fifo_count − wr_pending; adv = (credit > 0).
- rd_en_down = (state ∈ {IDLE, ROW}) && adv. accept = valid && rd_en_down.
- IDLE/ROW: filt_en = accept, filt_din = din. Each accept increments col. The accept at col=IMG_W-1 clears col and moves to PAD. IDLE→ROW on the first accept. ROW with no accept stays in ROW.
- PAD: filt_din=0, filt_en=adv. After ROW_PAD enabled cycles: if row=IMG_H-1 → FLUSH, else row++ → ROW.
- FLUSH: filt_din=0, filt_en=adv. After FLUSH_LEN enabled cycles → CLR.
- CLR (1 cycle): filt_rst=1, frame_done=1, filt_en=0, rd_en_down=0. Clears row, col and prime cnt. → IDLE.
- Write capture: wr_pending is a register that equals filt_en of the previous cycle. When wr_pending=1, prime cnt < FILT_LAT increments prime cnt and discards filt_dout; otherwise filt_dout is pushed to the FIFO.
- Every frame pushes IMG_H·(IMG_W+ROW_PAD)+FLUSH_LEN−FILT_LAT words. Pad and flush outputs are pushed like pixel outputs.
- FIFO: read when rd_en_up && !empty. rd_en_up while empty is ignored. A simultaneous push and pop leaves the count unchanged, and a push into a full FIFO is unreachable by construction.

## Timing
- Reset (async assert, sync release) clears state to IDLE, all counters, the FIFO and wr_pending.
- Output reset values: rd_en_down=1, filt_en=0, filt_din=0, filt_rst=0, valid_out=0, dout=0, empty=1, frame_done=0.
- filt_en, filt_din and rd_en_down are combinational from state, credit and valid.
- The FIFO push happens on the edge after the filt_dout update, so a pushed word is visible as empty=0 one cycle after that push.
- Read: with rd_en_up=1 in cycle t, valid_out=1 and dout=data in cycle t+1. valid_out is otherwise 0 and dout holds its last value.
- Each stall (credit=0) freezes the sequencer and the filter pipeline. The order and content of pushed words are unaffected.
- Reset mid-frame discards the partial frame and FIFO contents. The next accepted pixel is treated as col 0, row 0.
- The frame_done pulse coincides with the filt_rst cycle. Pixels offered during CLR are held off and accepted in IDLE on the next cycle.

## Test plan
Directed tests use IMG_W=4, IMG_H=2, ROW_PAD=2, FLUSH_LEN=3, FILT_LAT=3 and FIFO_DEPTH=4, with a filter model that is a 3-stage delay advancing only on filt_en.
- Frame flow: valid held high, pixels 1..8, rd_en_up held high -> valid_out words exactly 1,2,3,4,0,0,5,6,7,8,0,0 (12 words). frame_done pulses once, filt_rst is high in that same cycle, and filt_en totals 15 cycles.
- Backpressure: rd_en_up=0 throughout -> at most 4 pushes, empty=0, then rd_en_down=0 and filt_en=0 with no overflow. Releasing rd_en_up then drains the same 12-word sequence.
- Gapped input: valid toggled every other cycle -> identical output sequence; PAD and FLUSH run without waiting on valid.
- Back-to-back frames: 16 pixels with valid continuous -> 24 words. The second frame's first output is pixel 9, not stale data from frame 1.
- Async reset: rst_n low mid-row 1 -> empty=1, valid_out=0 and rd_en_down=1 immediately. A fresh frame afterwards yields the frame-flow sequence.
- Read on empty: rd_en_up=1 with empty=1 -> valid_out stays 0 and the FIFO count is unchanged.
